// File: rtl/reset_release_sequencer_if.sv
`default_nettype none
// ============================================================================
// reset_release_sequencer_if : soft-reset request and sequenced reset outputs
// Revision: 1.0
// ============================================================================
interface reset_release_sequencer_if #(
  parameter int NUM_OUT = 3
);
  logic               iSwReset;
  logic [NUM_OUT-1:0] oResetN;
  logic               oReady;
  logic [1:0]         oState;

  modport master (
    output iSwReset,
    input  oResetN,
    input  oReady,
    input  oState
  );

  modport slave (
    input  iSwReset,
    output oResetN,
    output oReady,
    output oState
  );
endinterface
`default_nettype wire

// File: rtl/reset_release_sequencer.sv
`default_nettype none
// ============================================================================
// reset_release_sequencer : async-assert / sync-release, index-ordered resets
// Revision: 1.0
// ============================================================================
module reset_release_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_OUT     = 3,
  parameter int HOLD_CYCLES = 8,
  parameter int STEP_CYCLES = 4
) (
  input  wire logic                iClock,
  input  wire logic                iPreset,
  reset_release_sequencer_if.slave bus
);
  localparam int c_HW = $clog2(HOLD_CYCLES + 1);
  localparam int c_SW = $clog2(STEP_CYCLES + 1);
  localparam int c_IW = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

  localparam logic [c_HW-1:0] c_HOLD_LAST = c_HW'(HOLD_CYCLES - 1);
  localparam logic [c_SW-1:0] c_STEP_LAST = c_SW'(STEP_CYCLES - 1);
  localparam logic [c_IW-1:0] c_IDX_LAST  = c_IW'(NUM_OUT - 1);

  typedef enum logic [1:0] {
    S_RESET   = 2'd0,
    S_HOLD    = 2'd1,
    S_RELEASE = 2'd2,
    S_RUN     = 2'd3
  } state_t;

  state_t             r_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [c_HW-1:0]    r_hold_cnt;
  logic [c_SW-1:0]    r_step_cnt;
  logic [c_IW-1:0]    r_idx;
  logic [NUM_OUT-1:0] r_reset_n;
  logic               r_ready;

  logic               w_sync_q;
  logic [NUM_OUT-1:0] w_idx_mask;

  assign w_sync_q   = r_sync[SYNC_STAGES-1];
  assign w_idx_mask = NUM_OUT'(1) << r_idx;

  always_ff @(posedge iClock or negedge iPreset) begin
    if (!iPreset) begin
      r_state    <= S_RESET;
      r_sync     <= '0;
      r_hold_cnt <= '0;
      r_step_cnt <= '0;
      r_idx      <= '0;
      r_reset_n  <= '0;
      r_ready    <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], 1'b1};
      // Soft reset outranks sequencing and re-arms the hold on every high sample.
      if (r_state != S_RESET && bus.iSwReset) begin
        r_state    <= S_HOLD;
        r_hold_cnt <= '0;
        r_reset_n  <= '0;
        r_ready    <= 1'b0;
      end else begin
        case (r_state)
          S_RESET: begin
            if (w_sync_q) begin
              r_state    <= S_HOLD;
              r_hold_cnt <= '0;
            end
          end
          S_HOLD: begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
            if (r_hold_cnt == c_HOLD_LAST) begin
              r_reset_n[0] <= 1'b1;
              r_idx        <= c_IW'(1);
              r_step_cnt   <= '0;
              if (NUM_OUT == 1) begin
                r_state <= S_RUN;
                r_ready <= 1'b1;
              end else begin
                r_state <= S_RELEASE;
              end
            end
          end
          S_RELEASE: begin
            r_step_cnt <= r_step_cnt + 1'b1;
            if (r_step_cnt == c_STEP_LAST) begin
              r_reset_n  <= r_reset_n | w_idx_mask;
              r_step_cnt <= '0;
              if (r_idx == c_IDX_LAST) begin
                r_state <= S_RUN;
                r_ready <= 1'b1;
              end else begin
                r_idx <= r_idx + 1'b1;
              end
            end
          end
          S_RUN: begin
            r_state <= S_RUN;
          end
          default: begin
            r_state <= S_RESET;
          end
        endcase
      end
    end
  end

  assign bus.oResetN = r_reset_n;
  assign bus.oReady  = r_ready;
  assign bus.oState  = r_state;
endmodule
`default_nettype wire

// File: tb/tb_reset_release_sequencer.sv
`default_nettype none
// ============================================================================
// tb_reset_release_sequencer : scoreboard bench for the reset release sequencer
// Revision: 1.0
// ============================================================================
module tb_reset_release_sequencer;
  typedef struct {
    int         edge_n;
    logic [2:0] rn;
    logic       rdy;
    logic [1:0] st;
  } exp_t;

  logic clk;
  logic preset_n;
  logic preset1_n;
  int   edge_cnt;
  int   errors;
  int   checks;
  exp_t q[$];

  reset_release_sequencer_if #(.NUM_OUT(3)) bus ();
  reset_release_sequencer_if #(.NUM_OUT(1)) bus1 ();

  reset_release_sequencer #(
    .SYNC_STAGES(2), .NUM_OUT(3), .HOLD_CYCLES(8), .STEP_CYCLES(4)
  ) u_dut (
    .iClock (clk),
    .iPreset(preset_n),
    .bus    (bus)
  );

  reset_release_sequencer #(
    .SYNC_STAGES(2), .NUM_OUT(1), .HOLD_CYCLES(1), .STEP_CYCLES(4)
  ) u_dut1 (
    .iClock (clk),
    .iPreset(preset1_n),
    .bus    (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  function automatic void push(input int ed, input logic [2:0] rn, input logic rdy, input logic [1:0] st);
    exp_t e;
    e.edge_n = ed;
    e.rn     = rn;
    e.rdy    = rdy;
    e.st     = st;
    q.push_back(e);
  endfunction

  // Power-up release timing of the default configuration, edge numbers relative to release.
  function automatic void push_powerup();
    push(2,  3'b000, 1'b0, 2'd0);
    push(3,  3'b000, 1'b0, 2'd1);
    push(10, 3'b000, 1'b0, 2'd1);
    push(11, 3'b001, 1'b0, 2'd2);
    push(14, 3'b001, 1'b0, 2'd2);
    push(15, 3'b011, 1'b0, 2'd2);
    push(18, 3'b011, 1'b0, 2'd2);
    push(19, 3'b111, 1'b1, 2'd3);
  endfunction

  task automatic test_reset();
    int   base;
    int   guard;
    exp_t e;
    preset_n      = 1'b0;
    bus.iSwReset  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.oResetN !== 3'b000 || bus.oReady !== 1'b0 || bus.oState !== 2'd0) begin
      errors++;
      $display("FAIL reset_hold: got rn=%b rdy=%b st=%0d, want rn=000 rdy=0 st=0",
               bus.oResetN, bus.oReady, bus.oState);
    end
    @(negedge clk);
    bus.iSwReset = 1'b0;
    preset_n     = 1'b1;
    base         = edge_cnt;
    push_powerup();
    guard = 0;
    while (q.size() > 0 && guard < 40) begin
      @(posedge clk); #1; guard++;
      while (q.size() > 0 && q[0].edge_n == edge_cnt - base) begin
        e = q.pop_front();
        checks++;
        if (bus.oResetN !== e.rn || bus.oReady !== e.rdy || bus.oState !== e.st) begin
          errors++;
          $display("FAIL powerup edge %0d: got rn=%b rdy=%b st=%0d, want rn=%b rdy=%b st=%0d",
                   e.edge_n, bus.oResetN, bus.oReady, bus.oState, e.rn, e.rdy, e.st);
        end
      end
    end
    if (q.size() > 0) begin
      errors++; checks++;
      $display("FAIL powerup timeout: got %0d pending, want 0", q.size());
      q.delete();
    end
  endtask

  task automatic test_preset_mid();
    int   base;
    int   guard;
    exp_t e;
    preset_n = 1'b0;
    @(negedge clk);
    preset_n = 1'b1;
    base     = edge_cnt;
    repeat (15) @(posedge clk);
    #1;
    checks++;
    if (bus.oResetN !== 3'b011 || bus.oState !== 2'd2) begin
      errors++;
      $display("FAIL preset_mid_pre: got rn=%b st=%0d, want rn=011 st=2", bus.oResetN, bus.oState);
    end
    @(negedge clk);
    preset_n = 1'b0;
    #1;
    checks++;
    if (bus.oResetN !== 3'b000 || bus.oReady !== 1'b0 || bus.oState !== 2'd0) begin
      errors++;
      $display("FAIL preset_mid_async: got rn=%b rdy=%b st=%0d, want rn=000 rdy=0 st=0",
               bus.oResetN, bus.oReady, bus.oState);
    end
    #1;
    preset_n = 1'b1;
    base     = edge_cnt;
    push_powerup();
    guard = 0;
    while (q.size() > 0 && guard < 40) begin
      @(posedge clk); #1; guard++;
      while (q.size() > 0 && q[0].edge_n == edge_cnt - base) begin
        e = q.pop_front();
        checks++;
        if (bus.oResetN !== e.rn || bus.oReady !== e.rdy || bus.oState !== e.st) begin
          errors++;
          $display("FAIL restart edge %0d: got rn=%b rdy=%b st=%0d, want rn=%b rdy=%b st=%0d",
                   e.edge_n, bus.oResetN, bus.oReady, bus.oState, e.rn, e.rdy, e.st);
        end
      end
    end
    if (q.size() > 0) begin
      errors++; checks++;
      $display("FAIL restart timeout: got %0d pending, want 0", q.size());
      q.delete();
    end
  endtask

  // Soft-reset request high for len edges starting at edge e (relative edge 0).
  task automatic test_soft_reset(input int len);
    int   base;
    int   guard;
    int   last;
    exp_t e;
    last = len - 1;
    push(0, 3'b000, 1'b0, 2'd1);
    if (len > 1) push(last, 3'b000, 1'b0, 2'd1);
    push(last + 7,  3'b000, 1'b0, 2'd1);
    push(last + 8,  3'b001, 1'b0, 2'd2);
    push(last + 11, 3'b001, 1'b0, 2'd2);
    push(last + 12, 3'b011, 1'b0, 2'd2);
    push(last + 15, 3'b011, 1'b0, 2'd2);
    push(last + 16, 3'b111, 1'b1, 2'd3);
    @(negedge clk);
    bus.iSwReset = 1'b1;
    base         = edge_cnt + 1;
    guard        = 0;
    while (q.size() > 0 && guard < 40) begin
      @(posedge clk); #1; guard++;
      while (q.size() > 0 && q[0].edge_n == edge_cnt - base) begin
        e = q.pop_front();
        checks++;
        if (bus.oResetN !== e.rn || bus.oReady !== e.rdy || bus.oState !== e.st) begin
          errors++;
          $display("FAIL soft_len%0d edge e+%0d: got rn=%b rdy=%b st=%0d, want rn=%b rdy=%b st=%0d",
                   len, e.edge_n, bus.oResetN, bus.oReady, bus.oState, e.rn, e.rdy, e.st);
        end
      end
      if (edge_cnt - base >= last) bus.iSwReset = 1'b0;
    end
    bus.iSwReset = 1'b0;
    if (q.size() > 0) begin
      errors++; checks++;
      $display("FAIL soft_len%0d timeout: got %0d pending, want 0", len, q.size());
      q.delete();
    end
  endtask

  task automatic test_single_output();
    int   base;
    int   guard;
    logic saw2;
    exp_t e;
    push(2, 3'b000, 1'b0, 2'd0);
    push(3, 3'b000, 1'b0, 2'd1);
    push(4, 3'b001, 1'b1, 2'd3);
    push(8, 3'b001, 1'b1, 2'd3);
    saw2 = 1'b0;
    @(negedge clk);
    preset1_n = 1'b1;
    base      = edge_cnt;
    guard     = 0;
    while (q.size() > 0 && guard < 20) begin
      @(posedge clk); #1; guard++;
      if (bus1.oState === 2'd2) saw2 = 1'b1;
      while (q.size() > 0 && q[0].edge_n == edge_cnt - base) begin
        e = q.pop_front();
        checks++;
        if (bus1.oResetN !== e.rn[0] || bus1.oReady !== e.rdy || bus1.oState !== e.st) begin
          errors++;
          $display("FAIL single edge %0d: got rn=%b rdy=%b st=%0d, want rn=%b rdy=%b st=%0d",
                   e.edge_n, bus1.oResetN, bus1.oReady, bus1.oState, e.rn[0], e.rdy, e.st);
        end
      end
    end
    if (q.size() > 0) begin
      errors++; checks++;
      $display("FAIL single timeout: got %0d pending, want 0", q.size());
      q.delete();
    end
    checks++;
    if (saw2 !== 1'b0) begin
      errors++;
      $display("FAIL single_no_release_state: got saw_state2=%b, want 0", saw2);
    end
  endtask

  task automatic test_near_edge();
    int   base;
    int   first;
    int   dly;
    logic xseen;
    for (int it = 0; it < 5; it++) begin
      preset_n = 1'b0;
      @(posedge clk);
      dly = (it == 0) ? 9 : int'($urandom_range(1, 9));
      #(dly);
      preset_n = 1'b1;
      base     = edge_cnt;
      first    = -1;
      xseen    = 1'b0;
      for (int k = 0; k < 30 && first < 0; k++) begin
        @(posedge clk); #1;
        if ($isunknown({bus.oResetN, bus.oReady, bus.oState})) xseen = 1'b1;
        if (bus.oResetN[0] === 1'b1) first = edge_cnt - base;
      end
      checks++;
      if (xseen !== 1'b0) begin
        errors++;
        $display("FAIL near_edge_x it%0d: got X on outputs, want none", it);
      end
      checks++;
      if (first != 11 && first != 12) begin
        errors++;
        $display("FAIL near_edge_first it%0d: got first release edge %0d, want 11 or 12", it, first);
      end
    end
  endtask

  initial begin
    errors       = 0;
    checks       = 0;
    preset_n     = 1'b0;
    preset1_n    = 1'b0;
    bus.iSwReset = 1'b0;
    bus1.iSwReset = 1'b0;
    test_reset();
    test_preset_mid();
    test_soft_reset(1);
    test_soft_reset(5);
    test_single_output();
    test_near_edge();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
